// File: rtl/uart_rx_if.sv
// Receive-buffer handshake between uart_rx and its consumer.
// Show-ahead: rx_data is the oldest byte whenever rx_valid is high.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a show-ahead byte FIFO.
// frame_err and overrun are registered single-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    uart_rx_if.master fifo,
    output logic      frame_err,
    output logic      overrun,
    output logic      busy
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(CPB - 1);
    localparam logic [AW:0]   FULL_N = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, WAIT_IDLE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          rx_meta, rxs;
    logic          push, ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer + TW'(1);
        idx_n   = idx;
        shreg_n = shreg;
        push    = 1'b0;
        ferr    = 1'b0;
        unique case (state)
            IDLE: begin
                timer_n = '0;
                if (!rxs) state_n = START;
            end
            START: begin
                if (timer == T_HALF) begin
                    timer_n = '0;
                    idx_n   = '0;
                    state_n = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == T_BIT) begin
                    timer_n      = '0;
                    shreg_n[idx] = rxs;
                    idx_n        = idx + 3'd1;
                    if (idx == 3'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (timer == T_BIT) begin
                    timer_n = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr    = 1'b1;
                        state_n = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                timer_n = '0;
                if (rxs) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign fifo.rx_valid = (count != '0);
    assign fifo.rx_data  = fifo.rx_valid ? mem[rd_ptr] : 8'h00;
    assign full          = (count == FULL_N);
    assign pop           = fifo.rx_valid && fifo.rx_ready;
    // A simultaneous pop frees the slot the incoming byte needs.
    assign wr            = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            frame_err <= ferr;
            overrun   <= push && full && !pop;
        end
    end
endmodule
